// File: rtl/mcu_rgb_assembler_if.sv
// rtl/mcu_rgb_assembler_if.sv - block input, pixel output and error-flag bundle of the MCU RGB assembler
interface mcu_rgb_assembler_if;
    logic [3:0]             valid_in;
    logic [1:0]             ch_in;
    logic [7:0][7:0][7:0]   block_1_in;
    logic [7:0][7:0][7:0]   block_2_in;
    logic [7:0][7:0][7:0]   block_3_in;
    logic [7:0][7:0][7:0]   block_4_in;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_r;
    logic [7:0]             out_g;
    logic [7:0]             out_b;
    logic [3:0]             out_x;
    logic [3:0]             out_y;
    logic                   out_last;
    logic                   err_clr;
    logic                   err_proto;
    logic                   err_ovf;

    modport master (
        output valid_in, ch_in, block_1_in, block_2_in, block_3_in, block_4_in,
        output out_ready, err_clr,
        input  in_ready, out_valid, out_r, out_g, out_b, out_x, out_y, out_last,
        input  err_proto, err_ovf
    );

    modport slave (
        input  valid_in, ch_in, block_1_in, block_2_in, block_3_in, block_4_in,
        input  out_ready, err_clr,
        output in_ready, out_valid, out_r, out_g, out_b, out_x, out_y, out_last,
        output err_proto, err_ovf
    );
endinterface

// File: rtl/mcu_rgb_assembler.sv
// rtl/mcu_rgb_assembler.sv - gathers a 4:2:0 MCU, converts YCbCr to RGB and streams 16x16 pixels
module mcu_rgb_assembler #(
    parameter int FRAC   = 8,
    parameter int K_CR_R = 359,
    parameter int K_CB_G = 88,
    parameter int K_CR_G = 183,
    parameter int K_CB_B = 454
) (
    input  logic            clk,
    input  logic            rst,
    mcu_rgb_assembler_if.slave bus
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    // 20-bit signed coefficients keep every partial sum inside the accumulator range
    localparam logic signed [19:0] KCRR = 20'(K_CR_R);
    localparam logic signed [19:0] KCBG = 20'(K_CB_G);
    localparam logic signed [19:0] KCRG = 20'(K_CR_G);
    localparam logic signed [19:0] KCBB = 20'(K_CB_B);
    localparam logic signed [19:0] RND  = 20'(2 ** (FRAC - 1));

    state_t     state;
    logic [2:0] y_cnt;
    logic       cb_got;
    logic       cr_got;
    logic [7:0] idx;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic       out_last;
    logic       err_proto;
    logic       err_ovf;

    // quadrant index 0..3 = TL,TR,BL,BR; each quadrant is [row][col]
    logic [3:0][7:0][7:0][7:0] y_buf;
    logic [3:0][7:0][7:0][7:0] cb_buf;
    logic [3:0][7:0][7:0][7:0] cr_buf;

    logic       beat;
    logic       y_ok;
    logic       cb_ok;
    logic       cr_ok;
    logic       legal;
    logic       accept;
    logic [2:0] y_cnt_nx;
    logic       complete;

    assign beat     = |bus.valid_in;
    assign y_ok     = beat && (bus.ch_in == 2'd0) && (bus.valid_in == 4'b0001) && (y_cnt < 3'd4);
    assign cb_ok    = beat && (bus.ch_in == 2'd1) && (bus.valid_in == 4'b1111) && !cb_got;
    assign cr_ok    = beat && (bus.ch_in == 2'd2) && (bus.valid_in == 4'b1111) && !cr_got;
    assign legal    = y_ok || cb_ok || cr_ok;
    assign accept   = (state == COLLECT) && legal;
    assign y_cnt_nx = y_cnt + {2'b00, y_ok};
    assign complete = accept && (y_cnt_nx == 3'd4) && (cb_got || cb_ok) && (cr_got || cr_ok);

    // The pixel to present next: 0 on DRAIN entry, otherwise the successor of the shown one
    logic [7:0] load_idx;
    logic [3:0] lx;
    logic [3:0] ly;
    logic [1:0] quad;
    logic [7:0] pix_y;
    logic [7:0] pix_cb;
    logic [7:0] pix_cr;

    assign load_idx = out_valid ? idx + 8'd1 : 8'd0;
    assign lx       = load_idx[3:0];
    assign ly       = load_idx[7:4];
    assign quad     = {ly[3], lx[3]};
    assign pix_y    = y_buf[quad][ly[2:0]][lx[2:0]];
    assign pix_cb   = cb_buf[quad][ly[2:0]][lx[2:0]];
    assign pix_cr   = cr_buf[quad][ly[2:0]][lx[2:0]];

    logic signed [19:0] y_s;
    logic signed [19:0] d_cb;
    logic signed [19:0] d_cr;
    logic signed [19:0] r_acc;
    logic signed [19:0] g_acc;
    logic signed [19:0] b_acc;

    assign y_s   = signed'({12'd0, pix_y});
    assign d_cb  = signed'({12'd0, pix_cb}) - 20'sd128;
    assign d_cr  = signed'({12'd0, pix_cr}) - 20'sd128;
    assign r_acc = (y_s <<< FRAC) + KCRR * d_cr + RND;
    assign g_acc = (y_s <<< FRAC) - KCBG * d_cb - KCRG * d_cr + RND;
    assign b_acc = (y_s <<< FRAC) + KCBB * d_cb + RND;

    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        if (v[19])
            return 8'd0;
        else if (v > 20'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    // Capture accepted beats; an illegal or late beat leaves the buffers untouched
    always_ff @(posedge clk) begin
        if (state == COLLECT) begin
            if (y_ok)
                y_buf[y_cnt[1:0]] <= bus.block_1_in;
            if (cb_ok)
                cb_buf <= {bus.block_4_in, bus.block_3_in, bus.block_2_in, bus.block_1_in};
            if (cr_ok)
                cr_buf <= {bus.block_4_in, bus.block_3_in, bus.block_2_in, bus.block_1_in};
        end
    end

    // Collect/drain FSM with registered pixel outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            y_cnt     <= 3'd0;
            cb_got    <= 1'b0;
            cr_got    <= 1'b0;
            idx       <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_r     <= 8'd0;
            out_g     <= 8'd0;
            out_b     <= 8'd0;
            out_x     <= 4'd0;
            out_y     <= 4'd0;
            out_last  <= 1'b0;
            err_proto <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            // a new error event on the clear edge keeps the flag set
            err_proto <= (err_proto && !bus.err_clr) || ((state == COLLECT) && beat && !legal);
            err_ovf   <= (err_ovf && !bus.err_clr) || ((state == DRAIN) && beat);
            case (state)
                COLLECT: begin
                    if (accept) begin
                        y_cnt <= y_cnt_nx;
                        if (cb_ok)
                            cb_got <= 1'b1;
                        if (cr_ok)
                            cr_got <= 1'b1;
                        if (complete) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || bus.out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            state     <= COLLECT;
                            in_ready  <= 1'b1;
                            y_cnt     <= 3'd0;
                            cb_got    <= 1'b0;
                            cr_got    <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            idx       <= load_idx;
                            out_r     <= clamp8(r_acc >>> FRAC);
                            out_g     <= clamp8(g_acc >>> FRAC);
                            out_b     <= clamp8(b_acc >>> FRAC);
                            out_x     <= lx;
                            out_y     <= ly;
                            out_last  <= (load_idx == 8'hFF);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_r     = out_r;
    assign bus.out_g     = out_g;
    assign bus.out_b     = out_b;
    assign bus.out_x     = out_x;
    assign bus.out_y     = out_y;
    assign bus.out_last  = out_last;
    assign bus.err_proto = err_proto;
    assign bus.err_ovf   = err_ovf;

endmodule
